// File: rtl/reliable_pkg.sv
// Shared types and sizing helpers for the bundle decoder.
package reliable_pkg;

  // Decoder control states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } decoder_state_t;

  // Width of the saturating ambiguous-decode counter.
  localparam int AMBIG_CNT_W = 16;

  // Bits needed to hold a count from 0 to n inclusive.
  function automatic int count_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  // Number of CHUNK-wide slices needed to cover n bits.
  function automatic int chunk_count(input int n, input int chunk);
    return (n + chunk - 1) / chunk;
  endfunction

endpackage

// File: rtl/popcount_chunk.sv
// Combinational popcount of one CHUNK-bit slice.
module popcount_chunk
  import reliable_pkg::*;
#(
  parameter int CHUNK = 4,
  localparam int CW = count_width(CHUNK)
) (
  input  logic [CHUNK-1:0] slice_i,
  output logic [CW-1:0]    count_o
);

  // Sum the individual bits of the slice.
  always_comb begin
    count_o = '0;
    for (int i = 0; i < CHUNK; i++) begin
      count_o = count_o + CW'(slice_i[i]);
    end
  end

endmodule

// File: rtl/bundle_decoder.sv
// Threshold decoder for a multiplexed NAND-chain excitation bundle.
// The captured bundle is popcounted one CHUNK-wide slice per clock and the
// final count is mapped to a logic value, with an ambiguity flag for counts
// that fall strictly between the two thresholds.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1; in_ready_o is high only in IDLE, out_valid_o only in DONE, and the
// result outputs are frozen while out_valid_o waits for out_ready_i.
module bundle_decoder
  import reliable_pkg::*;
#(
  parameter int N         = 10,
  parameter int CHUNK     = 4,
  parameter int HI_THRESH = 7,
  parameter int LO_THRESH = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N-1:0]             bundle_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  output logic                     bit_o,
  output logic                     ambig_o,
  output logic [$clog2(N+1)-1:0]   ones_o,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [AMBIG_CNT_W-1:0]   ambig_cnt_o
);

  localparam int ACC_W = count_width(N);
  localparam int PC_W  = count_width(CHUNK);
  localparam int C     = chunk_count(N, CHUNK);
  localparam int IW    = (C > 1) ? $clog2(C) : 1;
  localparam int PAD_W = C * CHUNK;

  // Elaboration-time parameter legality.
  if (CHUNK < 1 || CHUNK > N) begin : g_bad_chunk
    $error("bundle_decoder: CHUNK must lie in 1..N");
  end
  if (!(LO_THRESH < HI_THRESH) || HI_THRESH > N) begin : g_bad_thresh
    $error("bundle_decoder: need LO_THRESH < HI_THRESH <= N");
  end

  decoder_state_t          state_q, state_d;
  logic [N-1:0]            bundle_q, bundle_d;
  logic [ACC_W-1:0]        acc_q, acc_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic                    bit_q, bit_d;
  logic                    ambig_q, ambig_d;
  logic [ACC_W-1:0]        ones_q, ones_d;
  logic [AMBIG_CNT_W-1:0]  ambig_cnt_q, ambig_cnt_d;

  // Bundle zero-extended to a whole number of slices so the top slice pads with 0.
  logic [PAD_W-1:0]        padded;
  logic [CHUNK-1:0]        slices [C];
  logic [CHUNK-1:0]        slice_cur;
  logic [PC_W-1:0]         pc_count;
  logic [ACC_W-1:0]        count_sum;

  assign padded = PAD_W'(bundle_q);

  for (genvar g = 0; g < C; g++) begin : g_slice
    assign slices[g] = padded[g*CHUNK +: CHUNK];
  end

  // Select the slice addressed by the chunk index.
  always_comb begin
    slice_cur = '0;
    for (int g = 0; g < C; g++) begin
      if (idx_q == IW'(g)) slice_cur = slices[g];
    end
  end

  popcount_chunk #(.CHUNK(CHUNK)) u_popcount (
    .slice_i (slice_cur),
    .count_o (pc_count)
  );

  assign count_sum = acc_q + ACC_W'(pc_count);

  // Next-state, accumulation and decision logic.
  always_comb begin
    state_d     = state_q;
    bundle_d    = bundle_q;
    acc_d       = acc_q;
    idx_d       = idx_q;
    bit_d       = bit_q;
    ambig_d     = ambig_q;
    ones_d      = ones_q;
    ambig_cnt_d = ambig_cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          bundle_d = bundle_i;
          acc_d    = '0;
          idx_d    = '0;
          state_d  = COUNT;
        end
      end
      COUNT: begin
        acc_d = count_sum;
        idx_d = idx_q + IW'(1);
        if (idx_q == IW'(C - 1)) begin
          state_d = DONE;
          ones_d  = count_sum;
          if (count_sum >= ACC_W'(HI_THRESH)) begin
            bit_d   = 1'b1;
            ambig_d = 1'b0;
          end else if (count_sum <= ACC_W'(LO_THRESH)) begin
            bit_d   = 1'b0;
            ambig_d = 1'b0;
          end else begin
            // Ambiguous: keep the last decided value and log the event.
            ambig_d = 1'b1;
            if (ambig_cnt_q != {AMBIG_CNT_W{1'b1}}) begin
              ambig_cnt_d = ambig_cnt_q + AMBIG_CNT_W'(1);
            end
          end
        end
      end
      DONE: begin
        if (out_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      bundle_q    <= '0;
      acc_q       <= '0;
      idx_q       <= '0;
      bit_q       <= 1'b0;
      ambig_q     <= 1'b0;
      ones_q      <= '0;
      ambig_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      bundle_q    <= bundle_d;
      acc_q       <= acc_d;
      idx_q       <= idx_d;
      bit_q       <= bit_d;
      ambig_q     <= ambig_d;
      ones_q      <= ones_d;
      ambig_cnt_q <= ambig_cnt_d;
    end
  end

  assign in_ready_o  = (state_q == IDLE);
  assign out_valid_o = (state_q == DONE);
  assign bit_o       = bit_q;
  assign ambig_o     = ambig_q;
  assign ones_o      = ones_q;
  assign ambig_cnt_o = ambig_cnt_q;

endmodule

// File: tb/tb_bundle_decoder.sv
// Bench for bundle_decoder: directed cases, randomized bundles checked against
// a threshold model, reset abort, CHUNK=3 padding and counter saturation.
module tb_bundle_decoder;

  localparam int N  = 10;
  localparam int HI = 7;
  localparam int LO = 3;
  localparam int C  = 3;   // ceil(10/4)
  localparam int C3 = 4;   // ceil(10/3)
  localparam int EW = 22;  // {bit, ambig, ones[3:0], cnt[15:0]}

  // Clock and reset.
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Default-parameter DUT.
  logic [N-1:0] bundle_i;
  logic         in_valid_i, in_ready_o, bit_o, ambig_o, out_valid_o, out_ready_i;
  logic [3:0]   ones_o;
  logic [15:0]  ambig_cnt_o;

  bundle_decoder dut (
    .clk(clk), .reset(reset), .bundle_i(bundle_i), .in_valid_i(in_valid_i),
    .in_ready_o(in_ready_o), .bit_o(bit_o), .ambig_o(ambig_o), .ones_o(ones_o),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .ambig_cnt_o(ambig_cnt_o)
  );

  // CHUNK=3 DUT for the padded-slice case.
  logic [N-1:0] b3;
  logic         v3, rdy3, bit3, amb3, ov3, ordy3;
  logic [3:0]   ones3;
  logic [15:0]  cnt3;

  bundle_decoder #(.N(10), .CHUNK(3), .HI_THRESH(7), .LO_THRESH(3)) dut3 (
    .clk(clk), .reset(reset), .bundle_i(b3), .in_valid_i(v3),
    .in_ready_o(rdy3), .bit_o(bit3), .ambig_o(amb3), .ones_o(ones3),
    .out_valid_o(ov3), .out_ready_i(ordy3), .ambig_cnt_o(cnt3)
  );

  // Scoreboard.
  int checks = 0;
  int errors = 0;
  logic [EW-1:0] exp_q[$];
  logic        m_bit = 1'b0;
  logic [15:0] m_cnt = 16'h0;
  logic        m3_bit = 1'b0;
  logic [15:0] m3_cnt = 16'h0;
  int last_acc = 0;
  int prev_acc = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Threshold rule: >=HI -> 1, <=LO -> 0, otherwise hold and count.
  task automatic decide(input int ones, inout logic b, output logic amb, inout logic [15:0] cnt);
    amb = 1'b0;
    if (ones >= HI) b = 1'b1;
    else if (ones <= LO) b = 1'b0;
    else begin
      amb = 1'b1;
      if (cnt != 16'hFFFF) cnt = cnt + 16'h1;
    end
  endtask

  task automatic model_push(input logic [N-1:0] b);
    int ones;
    logic amb;
    ones = $countones(b);
    decide(ones, m_bit, amb, m_cnt);
    exp_q.push_back({m_bit, amb, 4'(ones), m_cnt});
  endtask

  // Driver: called #1 after an edge with the DUT in IDLE.
  task automatic run_bundle(input logic [N-1:0] b, input int hold);
    int edges;
    logic [EW-1:0] e;
    check("in_ready_idle", in_ready_o, 1);
    model_push(b);
    bundle_i    = b;
    in_valid_i  = 1'b1;
    out_ready_i = (hold == 0);
    @(posedge clk); #1;
    prev_acc = last_acc;
    last_acc = cyc;
    edges = 1;
    check("in_ready_busy", in_ready_o, 0);
    while (!out_valid_o && edges < 20) begin
      bundle_i   = N'($urandom);
      in_valid_i = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      edges++;
    end
    in_valid_i = 1'b0;
    check("latency", edges, C + 1);
    e = exp_q.pop_front();
    check("out_valid", out_valid_o, 1);
    check("bit", bit_o, e[21]);
    check("ambig", ambig_o, e[20]);
    check("ones", ones_o, e[19:16]);
    check("ambig_cnt", ambig_cnt_o, e[15:0]);
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      check("hold_valid", out_valid_o, 1);
      check("hold_in_ready", in_ready_o, 0);
      check("hold_bit", bit_o, e[21]);
      check("hold_ones", ones_o, e[19:16]);
    end
    out_ready_i = 1'b1;
    @(posedge clk); #1;
    check("release_valid", out_valid_o, 0);
    check("release_in_ready", in_ready_o, 1);
    check("kept_bit", bit_o, e[21]);
    check("kept_ambig", ambig_o, e[20]);
    check("kept_ones", ones_o, e[19:16]);
  endtask

  // Driver for the CHUNK=3 instance (out_ready tied high).
  task automatic run3(input logic [N-1:0] b);
    int edges;
    int ones;
    logic amb;
    ones = $countones(b);
    decide(ones, m3_bit, amb, m3_cnt);
    b3 = b;
    v3 = 1'b1;
    @(posedge clk); #1;
    v3 = 1'b0;
    edges = 1;
    while (!ov3 && edges < 20) begin
      @(posedge clk); #1;
      edges++;
    end
    check("c3_latency", edges, C3 + 1);
    check("c3_ones", ones3, ones);
    check("c3_bit", bit3, m3_bit);
    check("c3_ambig", amb3, amb);
    check("c3_cnt", cnt3, m3_cnt);
    @(posedge clk); #1;
    check("c3_release", rdy3, 1);
  endtask

  initial begin
    reset = 1'b1;
    bundle_i = '0; in_valid_i = 1'b0; out_ready_i = 1'b1;
    b3 = '0; v3 = 1'b0; ordy3 = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state.
    check("rst_in_ready", in_ready_o, 1);
    check("rst_out_valid", out_valid_o, 0);
    check("rst_bit", bit_o, 0);
    check("rst_ambig", ambig_o, 0);
    check("rst_ones", ones_o, 0);
    check("rst_cnt", ambig_cnt_o, 0);

    // Directed cases.
    run_bundle(10'h3FF, 0);
    run_bundle(10'h007, 0);
    run_bundle(10'h01F, 0);
    check("throughput", last_acc - prev_acc, C + 2);
    run_bundle(10'h07F, 5);
    run_bundle(10'h000, 0);
    run_bundle(10'h0F0, 1);

    // Randomized bundles with random backpressure.
    for (int i = 0; i < 40; i++) begin
      run_bundle(N'($urandom_range(0, 1023)), $urandom_range(0, 2));
    end

    // Reset during the second COUNT edge discards the bundle.
    bundle_i = 10'h3F0; in_valid_i = 1'b1;
    @(posedge clk); #1;
    in_valid_i = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    m_bit = 1'b0; m_cnt = 16'h0; m3_bit = 1'b0; m3_cnt = 16'h0;
    check("abort_in_ready", in_ready_o, 1);
    check("abort_bit", bit_o, 0);
    check("abort_ambig", ambig_o, 0);
    check("abort_ones", ones_o, 0);
    check("abort_cnt", ambig_cnt_o, 0);
    for (int k = 0; k < 6; k++) begin
      check("abort_no_valid", out_valid_o, 0);
      @(posedge clk); #1;
    end
    run_bundle(10'h3FF, 0);

    // CHUNK=3: top slice has two padding bits.
    run3(10'h200);
    run3(10'h3FE);
    run3(10'h155);
    run3(10'h201);

    // Saturation: preload near the top, then drive ambiguous bundles.
    dut.ambig_cnt_q = 16'hFFFD;
    m_cnt = 16'hFFFD;
    run_bundle(10'h01F, 0);
    run_bundle(10'h2A8, 0);
    run_bundle(10'h33C, 0);
    run_bundle(10'h3FF, 0);
    check("sat_final", ambig_cnt_o, 16'hFFFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bundle_decoder.md
BUNDLE_DECODER -- requirements
Module: bundle_decoder

Interface
REQ-001 The block SHALL have parameter N, default 10: bundle width in wires.
REQ-002 The block SHALL have parameter CHUNK, default 4: bundle bits counted per clock, legal range 1..N.
REQ-003 The block SHALL have parameter HI_THRESH, default 7: ones-count at or above which the bundle decodes to 1.
REQ-004 The block SHALL have parameter LO_THRESH, default 3: ones-count at or below which the bundle decodes to 0; LO_THRESH < HI_THRESH <= N.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit: reset, synchronous, active-high.
REQ-007 The block SHALL have port bundle_i, input, N bits: excitation bundle from the multiplexed NAND chain.
REQ-008 The block SHALL have port in_valid_i, input, 1 bit: bundle_i valid.
REQ-009 The block SHALL have port in_ready_o, output, 1 bit: decoder can accept a bundle.
REQ-010 The block SHALL have port bit_o, output, 1 bit: decoded logic value.
REQ-011 The block SHALL have port ambig_o, output, 1 bit: ones-count fell strictly between LO_THRESH and HI_THRESH.
REQ-012 The block SHALL have port ones_o, output, $clog2(N+1) bits: ones-count of the decoded bundle.
REQ-013 The block SHALL have port out_valid_o, output, 1 bit: bit_o, ambig_o and ones_o valid.
REQ-014 The block SHALL have port out_ready_i, input, 1 bit: downstream accepts the result.
REQ-015 The block SHALL have port ambig_cnt_o, output, 16 bits: saturating count of ambiguous decodes.

Function
REQ-016 The FSM SHALL have states IDLE, COUNT and DONE; in_ready_o SHALL be 1 only in IDLE, and out_valid_o SHALL be 1 only in DONE.
REQ-017 In IDLE, when in_valid_i and in_ready_o are both 1 at an edge, the block SHALL register bundle_i, clear the accumulator and chunk index, and go to COUNT.
REQ-018 In COUNT, the block SHALL add the popcount of one CHUNK-wide slice per edge, LSB slice first; slice bits at index >= N SHALL count as 0.
REQ-019 COUNT SHALL last C = ceil(N/CHUNK) edges; on the C-th edge the FSM SHALL go to DONE with the final count registered.
REQ-020 out_valid_o SHALL rise exactly C+1 edges after the accepting edge (default: 4).
REQ-021 On entry to DONE, the block SHALL apply this decision to ones_o = count:
- count >= HI_THRESH: bit_o=1, ambig_o=0
- count <= LO_THRESH: bit_o=0, ambig_o=0
- otherwise: ambig_o=1, bit_o holds the previously decided value, and ambig_cnt_o increments, saturating at 16'hFFFF.
REQ-022 In DONE, bit_o, ambig_o and ones_o SHALL stay stable until out_ready_i is 1 at an edge; the FSM SHALL then go to IDLE.
REQ-023 bit_o, ambig_o and ones_o SHALL keep their values outside DONE.
REQ-024 Throughput SHALL be one bundle per C+2 cycles with out_ready_i tied to 1.
REQ-025 Changes on bundle_i or in_valid_i outside IDLE SHALL have no effect.
REQ-026 Accumulator width SHALL be $clog2(N+1) bits; overflow is impossible by construction.

Reset
REQ-027 While reset is 1 at an edge, the block SHALL go to IDLE and clear bit_o, ambig_o, ones_o, ambig_cnt_o, the accumulator and the captured bundle to 0; out_valid_o SHALL then be 0 and in_ready_o 1.
REQ-028 A reset asserted in COUNT or DONE SHALL discard the in-flight bundle without producing a result.

Structure
REQ-029 Package reliable_pkg SHALL hold the decoder_state_t enum (IDLE, COUNT, DONE) and the count-width constant function.
REQ-030 The block SHALL contain one sub-module, popcount_chunk: a combinational CHUNK-bit popcount instantiated once and fed the current slice.
REQ-031 Parameter legality SHALL be checked by elaboration-time assertions.

Verification
REQ-032 Defaults; bundle 10'h3FF, out_ready=1 -> out_valid high 4 edges after accept; bit_o=1, ones_o=10, ambig_o=0.
REQ-033 Bundle 10'h007 (3 ones) -> bit_o=0, ones_o=3, ambig_o=0; then 10'h01F (5 ones) -> ambig_o=1, bit_o stays 0, ambig_cnt_o=1.
REQ-034 Bundle 10'h07F (7 ones) with out_ready held 0 for 5 cycles -> out_valid and bit_o=1 held stable, in_ready=0; release -> IDLE the next edge.
REQ-035 Reset pulsed during the second COUNT edge -> no out_valid; all outputs 0; next bundle 10'h3FF decodes normally.
REQ-036 N=10, CHUNK=3 (C=4), bundle 10'h200 -> ones_o=1, bit_o=0, out_valid 5 edges after accept; upper slice padding counts as 0.
REQ-037 65537 consecutive ambiguous bundles -> ambig_cnt_o saturates at 16'hFFFF.
